// File: rtl/wb_commit.sv
// Write-back commit: arbitrates ALU results and buffered loads onto the
// single register-file write port and tracks outstanding loads.
module wb_commit #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_reg,
    input  logic [31:0] alu_data,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [4:0]  ld_reg,
    input  logic [31:0] ld_word,
    input  logic [1:0]  ld_size,
    input  logic        ld_unsigned,
    input  logic [1:0]  ld_offset,
    input  logic        claim_valid,
    input  logic [4:0]  claim_reg,
    input  logic [4:0]  read1,
    input  logic [4:0]  read2,
    output logic        hazard1,
    output logic        hazard2,
    output logic [31:0] pending,
    output logic        RegWrite,
    output logic [4:0]  write_reg,
    output logic [31:0] write_data
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]            fifo_reg  [FIFO_DEPTH];
    logic [31:0]           fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_live;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic        full;
    logic        accept;
    logic        pop;
    logic        alu_hit;
    logic        wb_load;
    logic [4:0]  head_reg;
    logic [31:0] head_data;
    logic        head_live;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;
    logic [31:0] set_mask;
    logic [31:0] clear_mask;

    assign full     = (count == CW'(FIFO_DEPTH));
    assign ld_ready = !full && rst;
    assign accept   = ld_valid && ld_ready;
    assign pop      = !alu_valid && (count != '0);
    assign alu_hit  = alu_valid && (alu_reg != 5'd0);

    assign head_reg  = fifo_reg[rd_ptr];
    assign head_data = fifo_data[rd_ptr];
    assign head_live = fifo_live[rd_ptr];

    assign hazard1 = (read1 != 5'd0) && pending[read1];
    assign hazard2 = (read2 != 5'd0) && pending[read2];

    always_comb begin
        ld_byte = ld_word[{ld_offset, 3'b000} +: 8];
        ld_half = ld_offset[1] ? ld_word[31:16] : ld_word[15:0];
        unique case (ld_size)
            2'b00:   ld_ext = {{24{ld_byte[7] & ~ld_unsigned}}, ld_byte};
            2'b01:   ld_ext = {{16{ld_half[15] & ~ld_unsigned}}, ld_half};
            default: ld_ext = ld_word;
        endcase
    end

    // Live loads release their register only once the write has landed.
    always_comb begin
        set_mask   = '0;
        clear_mask = '0;
        if (claim_valid && claim_reg != 5'd0)
            set_mask[claim_reg] = 1'b1;
        if (RegWrite && wb_load)
            clear_mask[write_reg] = 1'b1;
        if (pop && (!head_live || head_reg == 5'd0))
            clear_mask[head_reg] = 1'b1;
    end

    // Squash before the accept write so a same-cycle load stays live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (alu_hit && fifo_reg[i] == alu_reg)
                fifo_live[i] <= 1'b0;
        end
        if (accept) begin
            fifo_reg[wr_ptr]  <= ld_reg;
            fifo_data[wr_ptr] <= ld_ext;
            fifo_live[wr_ptr] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            pending    <= '0;
            RegWrite   <= 1'b0;
            write_reg  <= 5'd0;
            write_data <= 32'd0;
            wb_load    <= 1'b0;
        end else begin
            if (accept)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count   <= count + CW'(accept) - CW'(pop);
            pending <= (pending & ~clear_mask) | set_mask;
            if (alu_valid) begin
                RegWrite   <= alu_reg != 5'd0;
                write_reg  <= alu_reg;
                write_data <= alu_data;
                wb_load    <= 1'b0;
            end else if (pop) begin
                RegWrite   <= head_live && head_reg != 5'd0;
                write_reg  <= head_reg;
                write_data <= head_data;
                wb_load    <= head_live;
            end else begin
                RegWrite   <= 1'b0;
                write_reg  <= 5'd0;
                write_data <= 32'd0;
                wb_load    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_commit.sv
// Bench for wb_commit: queue-based reference model feeding a scoreboard
// that a negedge monitor drains against the register-file write port.
module tb_wb_commit;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_reg;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_reg;
    logic [31:0] ld_word;
    logic [1:0]  ld_size;
    logic        ld_unsigned;
    logic [1:0]  ld_offset;
    logic        claim_valid;
    logic [4:0]  claim_reg;
    logic [4:0]  read1;
    logic [4:0]  read2;
    logic        hazard1;
    logic        hazard2;
    logic [31:0] pending;
    logic        RegWrite;
    logic [4:0]  write_reg;
    logic [31:0] write_data;

    wb_commit #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_reg(alu_reg),
        .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_reg(ld_reg), .ld_word(ld_word),
        .ld_size(ld_size), .ld_unsigned(ld_unsigned),
        .ld_offset(ld_offset),
        .claim_valid(claim_valid), .claim_reg(claim_reg),
        .read1(read1), .read2(read2),
        .hazard1(hazard1), .hazard2(hazard2),
        .pending(pending),
        .RegWrite(RegWrite), .write_reg(write_reg),
        .write_data(write_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        av;
        logic [4:0]  ar;
        logic [31:0] ad;
        logic        lv;
        logic [4:0]  lr;
        logic [31:0] lw;
        logic [1:0]  ls;
        logic        lu;
        logic [1:0]  lo;
        logic        cv;
        logic [4:0]  cr;
        logic [4:0]  r1;
        logic [4:0]  r2;
    } stim_t;

    typedef struct {
        logic [4:0]  rg;
        logic [31:0] data;
        logic        live;
    } ld_t;

    typedef struct {
        logic [4:0]  rg;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    ld_t  mq[$];
    exp_t eq[$];

    logic [31:0] mpend = '0;
    logic        clr_v = 1'b0;
    logic [4:0]  clr_reg = '0;
    logic        exp_ready = 1'b0;
    logic [31:0] exp_pend = '0;
    logic        mon_on = 1'b0;
    logic        dut_acc = 1'b0;
    logic [31:0] dut_rf [32];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ext(input logic [31:0] w,
                                        input logic [1:0] sz,
                                        input logic uns,
                                        input logic [1:0] off);
        logic [31:0] v;
        int nb;
        if (sz == 2'd0) begin
            nb = 8;
            v  = (w >> (8 * int'(off))) & 32'hFF;
        end else if (sz == 2'd1) begin
            nb = 16;
            v  = (w >> (off[1] ? 16 : 0)) & 32'hFFFF;
        end else begin
            return w;
        end
        if (!uns && v[nb-1])
            v = v | (32'hFFFF_FFFF << nb);
        return v;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{r: 1'b1, av: 1'b0, ar: 5'd0, ad: 32'd0,
              lv: 1'b0, lr: 5'd0, lw: 32'd0, ls: 2'd2,
              lu: 1'b0, lo: 2'd0, cv: 1'b0, cr: 5'd0,
              r1: 5'd0, r2: 5'd0};
        return s;
    endfunction

    // One cycle: apply inputs, advance the model, wait past the edge.
    task automatic drive(input stim_t s);
        ld_t e;
        logic [31:0] np;
        exp_ready = s.r && (mq.size() < DEPTH);
        exp_pend  = mpend;
        rst = s.r;
        alu_valid = s.av; alu_reg = s.ar; alu_data = s.ad;
        ld_valid = s.lv; ld_reg = s.lr; ld_word = s.lw;
        ld_size = s.ls; ld_unsigned = s.lu; ld_offset = s.lo;
        claim_valid = s.cv; claim_reg = s.cr;
        read1 = s.r1; read2 = s.r2;
        mon_on = 1'b1;
        if (!s.r) begin
            mq.delete();
            mpend = '0;
            clr_v = 1'b0;
        end else begin
            np = mpend;
            if (clr_v) np[clr_reg] = 1'b0;
            clr_v = 1'b0;
            if (s.av) begin
                if (s.ar != 5'd0) begin
                    eq.push_back('{s.ar, s.ad, cyc + 1});
                    foreach (mq[i])
                        if (mq[i].rg == s.ar) mq[i].live = 1'b0;
                end
            end else if (mq.size() > 0) begin
                e = mq.pop_front();
                if (e.live && e.rg != 5'd0) begin
                    eq.push_back('{e.rg, e.data, cyc + 1});
                    clr_v   = 1'b1;
                    clr_reg = e.rg;
                end else begin
                    np[e.rg] = 1'b0;
                end
            end
            if (s.lv && exp_ready)
                mq.push_back('{s.lr, ext(s.lw, s.ls, s.lu, s.lo), 1'b1});
            if (s.cv && s.cr != 5'd0) np[s.cr] = 1'b1;
            np[0] = 1'b0;
            mpend = np;
        end
        @(negedge clk);
        dut_acc = ld_valid && ld_ready;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t x;
        logic exp_we;
        if (mon_on) begin
            chk("ld_ready", {31'd0, ld_ready}, {31'd0, exp_ready});
            chk("pending", pending, exp_pend);
            chk("hazard1", {31'd0, hazard1},
                {31'd0, read1 != 5'd0 && exp_pend[read1]});
            chk("hazard2", {31'd0, hazard2},
                {31'd0, read2 != 5'd0 && exp_pend[read2]});
            if (rst && claim_valid && claim_reg != 5'd0)
                chk("claim_legal", {31'd0, pending[claim_reg]}, 32'd0);
            while (eq.size() > 0 && eq[0].cyc < cyc) begin
                chk("missing_write", {27'd0, eq[0].rg}, 32'hFFFF_FFFF);
                void'(eq.pop_front());
            end
            exp_we = (eq.size() > 0 && eq[0].cyc == cyc);
            chk("RegWrite", {31'd0, RegWrite}, {31'd0, exp_we});
            if (RegWrite === 1'b1) dut_rf[write_reg] = write_data;
            if (exp_we) begin
                x = eq.pop_front();
                if (RegWrite === 1'b1) begin
                    chk("write_reg", {27'd0, write_reg}, {27'd0, x.rg});
                    chk("write_data", write_data, x.data);
                end
            end
        end
    end

    task automatic idles(input int n);
        for (int i = 0; i < n; i++) drive(idle());
    endtask

    task automatic load_seq(input logic [1:0] sz, input logic uns,
                            input logic [1:0] off,
                            input logic [31:0] want);
        stim_t s;
        s = idle(); s.r1 = 5'd8; s.cv = 1'b1; s.cr = 5'd8;
        drive(s);
        chk("claim_set", {31'd0, pending[8]}, 32'd1);
        s = idle(); s.r1 = 5'd8; s.lv = 1'b1; s.lr = 5'd8;
        s.lw = 32'h80FF7F01; s.ls = sz; s.lu = uns; s.lo = off;
        drive(s);
        chk("haz_pop", {31'd0, hazard1}, 32'd1);
        s = idle(); s.r1 = 5'd8;
        drive(s);
        chk("ld_we", {31'd0, RegWrite}, 32'd1);
        chk("ld_data", write_data, want);
        chk("haz_wb", {31'd0, hazard1}, 32'd1);
        drive(s);
        chk("haz_drop", {31'd0, hazard1}, 32'd0);
    endtask

    initial begin
        stim_t s;
        int k;
        foreach (dut_rf[i]) dut_rf[i] = 32'd0;
        rst = 1'b0; alu_valid = 0; alu_reg = 0; alu_data = 0;
        ld_valid = 0; ld_reg = 0; ld_word = 0; ld_size = 0;
        ld_unsigned = 0; ld_offset = 0; claim_valid = 0;
        claim_reg = 0; read1 = 0; read2 = 0;
        @(posedge clk); #1;

        s = idle(); s.r = 1'b0;
        drive(s); drive(s);
        chk("rst_we", {31'd0, RegWrite}, 32'd0);
        chk("rst_wreg", {27'd0, write_reg}, 32'd0);
        chk("rst_wdata", write_data, 32'd0);
        chk("rst_pend", pending, 32'd0);
        chk("rst_ready", {31'd0, ld_ready}, 32'd0);
        idles(2);

        s = idle(); s.av = 1'b1; s.ar = 5'd5; s.ad = 32'h1234;
        drive(s);
        chk("alu_we", {31'd0, RegWrite}, 32'd1);
        chk("alu_reg", {27'd0, write_reg}, 32'd5);
        chk("alu_data", write_data, 32'h1234);
        s.ar = 5'd0; s.ad = 32'h55;
        drive(s);
        chk("alu_r0", {31'd0, RegWrite}, 32'd0);
        idles(2);

        load_seq(2'd0, 1'b0, 2'd3, 32'hFFFFFF80);
        load_seq(2'd1, 1'b1, 2'd2, 32'h000080FF);
        load_seq(2'd2, 1'b0, 2'd1, 32'h80FF7F01);
        idles(2);

        k = 0;
        for (int c = 0; c < 4; c++) begin
            s = idle(); s.av = 1'b1; s.ar = 5'(1 + c);
            s.ad = 32'(c); s.lv = (k < 3); s.lr = 5'(10 + k);
            s.lw = 32'h100 + 32'(k);
            drive(s);
            if (dut_acc) k++;
        end
        chk("bp_accepts", 32'(k), 32'd2);
        chk("bp_full", {31'd0, ld_ready}, 32'd0);
        for (int c = 0; c < 10 && k < 3; c++) begin
            s = idle(); s.lv = 1'b1; s.lr = 5'(10 + k);
            s.lw = 32'h100 + 32'(k);
            drive(s);
            if (dut_acc) k++;
        end
        chk("bp_third", 32'(k), 32'd3);
        idles(6);
        chk("bp_rf10", dut_rf[10], 32'h100);
        chk("bp_rf11", dut_rf[11], 32'h101);
        chk("bp_rf12", dut_rf[12], 32'h102);

        s = idle(); s.cv = 1'b1; s.cr = 5'd9;
        drive(s);
        s = idle(); s.lv = 1'b1; s.lr = 5'd9; s.lw = 32'h5555;
        drive(s);
        s = idle(); s.av = 1'b1; s.ar = 5'd9; s.ad = 32'hAAAA;
        drive(s);
        chk("sq_we", {31'd0, RegWrite}, 32'd1);
        chk("sq_data", write_data, 32'hAAAA);
        chk("sq_pend", {31'd0, pending[9]}, 32'd1);
        drive(idle());
        chk("sq_dead", {31'd0, RegWrite}, 32'd0);
        chk("sq_clr", {31'd0, pending[9]}, 32'd0);
        idles(4);
        chk("sq_rf9", dut_rf[9], 32'hAAAA);

        s = idle(); s.cv = 1'b1; s.cr = 5'd21;
        drive(s);
        s = idle(); s.av = 1'b1; s.ar = 5'd20; s.ad = 32'h20;
        s.lv = 1'b1; s.lr = 5'd21; s.lw = 32'h21;
        s.cv = 1'b1; s.cr = 5'd23;
        drive(s);
        s.ar = 5'd22; s.ad = 32'h22; s.lr = 5'd23; s.lw = 32'h23;
        s.cv = 1'b0;
        drive(s);
        chk("mr_busy", {31'd0, RegWrite}, 32'd1);
        s = idle(); s.r = 1'b0; s.av = 1'b1; s.ar = 5'd24;
        drive(s);
        chk("mr_we", {31'd0, RegWrite}, 32'd0);
        chk("mr_pend", pending, 32'd0);
        idles(6);
        chk("mr_rf21", dut_rf[21], 32'd0);
        chk("mr_rf23", dut_rf[23], 32'd0);

        for (int t = 0; t < 600; t++) begin
            s = idle();
            s.r  = ($urandom_range(0, 99) != 0);
            s.av = ($urandom_range(0, 9) < 4);
            s.ar = 5'($urandom_range(0, 7));
            s.ad = $urandom;
            s.lv = 1'($urandom_range(0, 1));
            s.lr = 5'($urandom_range(0, 7));
            s.lw = $urandom;
            s.ls = 2'($urandom_range(0, 3));
            s.lu = 1'($urandom_range(0, 1));
            s.lo = 2'($urandom_range(0, 3));
            s.cv = ($urandom_range(0, 4) == 0);
            s.cr = 5'($urandom_range(0, 7));
            if (mpend[s.cr]) s.cv = 1'b0;
            s.r1 = 5'($urandom_range(0, 7));
            s.r2 = 5'($urandom_range(0, 7));
            drive(s);
        end
        idles(8);
        mon_on = 1'b0;
        chk("drain", 32'(eq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_commit.md
# wb_commit

Write-back commit unit for the MIPS datapath: the producer side of the register file's single write port. Each cycle it merges ALU results and returned load data into at most one write, driving RegWrite, write_reg and write_data. Load data is sign- or zero-extended and held in a small FIFO while the port is busy. A pending-load scoreboard flags decode-stage read hazards.

## Interface
- FIFO_DEPTH, 2, load buffer entries; power of two, ≥2
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset; synchronous, active-low
- alu_valid  in  1  ALU result present this cycle; always accepted, no backpressure
- alu_reg  in  5  ALU destination register
- alu_data  in  32  ALU result
- ld_valid  in  1  load data present
- ld_ready  out  1  load buffer can accept
- ld_reg  in  5  load destination register
- ld_word  in  32  aligned memory word
- ld_size  in  2  00 byte, 01 half, 10/11 word
- ld_unsigned  in  1  1 = zero-extend, 0 = sign-extend
- ld_offset  in  2  byte address bits [1:0]
- claim_valid  in  1  decode issued a load to claim_reg
- claim_reg  in  5  register being claimed
- read1, read2  in  5  decode source registers
- hazard1, hazard2  out  1  source register has an outstanding load; combinational
- pending  out  32  scoreboard vector; bit 0 is always 0
- RegWrite  out  1  register-file write enable; registered
- write_reg  out  5  write address; registered
- write_data  out  32  write data; registered

## Operation
- Extraction on accept:
  - byte: ld_word[8*ld_offset +: 8]
  - half: ld_offset[1] selects the upper (1) or lower (0) 16 bits; ld_offset[0] is ignored
  - word: full word; offset ignored
  - extension: 32 bits, zero or sign per ld_unsigned
- FIFO entry holds reg (5), data (32) and a live bit. Accept when ld_valid && ld_ready; ld_ready = !full && rst.
- Port arbitration, one write per cycle:
  - alu_valid wins the port.
  - Otherwise the FIFO head pops if present.
  - A live head drives a write.
  - A dead (squashed) head pops with RegWrite 0.
- Register 0: any selected write with reg 0 drives RegWrite 0. A load to reg 0 is still accepted and popped.
- WAW squash: when alu_valid and alu_reg ≠ 0, every FIFO entry that was present before this edge and has reg == alu_reg becomes dead. A load accepted in the same cycle counts as younger and stays live.
- Scoreboard:
  - Set: pending[claim_reg] sets on claim_valid when claim_reg ≠ 0.
  - Clear: the bit clears when that register's load entry is dropped or committed:
    - a dead entry pops, or
    - a reg-0 pop occurs, or
    - a live entry's write commits (see Timing).
  - Set and clear for the same register on the same edge: set wins.
  - Claiming an already-pending register is illegal; decode stalls on hazard. The bench asserts it never occurs.
- hazardN = pending[readN]; always 0 when readN is 0.

## Timing
- Reset (rst low at a posedge):
  - FIFO emptied; entries discarded without writes.
  - pending = 0.
  - RegWrite = 0, write_reg = 0, write_data = 0.
  - ld_ready is 0 while rst is low and 1 on the first cycle after release.
  - Reset asserted mid-operation behaves the same: any in-flight write output is cleared at that edge.
- ALU path:
  - alu_valid in cycle N gives RegWrite/write_reg/write_data in cycle N+1.
  - The register file commits at the edge ending N+1.
- Load path:
  - Accepted at the edge ending cycle N; enters the FIFO.
  - Earliest pop is in cycle N+1, giving RegWrite in cycle N+2 and commit at the edge ending N+2.
  - Minimum accept-to-commit latency is 2 cycles.
- Scoreboard clear:
  - For a live load, pending clears at the commit edge (end of the RegWrite cycle). hazard is first low the following cycle, so decode never reads stale data.
  - For dead or reg-0 entries, pending clears at the pop edge.
- Full FIFO: ld_ready is low in the same cycle. A pop and an accept on the same edge are both allowed, but ld_ready reflects pre-edge fullness.
- Continuous alu_valid starves the FIFO. Backpressure propagates only through ld_ready.
- Pointer wrap-around: modulo FIFO_DEPTH, with a separate count register.

## Test plan
- Reset, then idle: RegWrite/write_reg/write_data all 0; pending = 0; ld_ready is 0 during reset and 1 one cycle after release.
- alu_valid, alu_reg = 5, alu_data = 0x1234 in cycle N: RegWrite = 1, write_reg = 5, write_data = 0x1234 in cycle N+1. A follow-up with alu_reg = 0 gives RegWrite 0.
- claim_reg = 8; then a load with ld_reg = 8, ld_word = 0x80FF7F01:
  - byte, signed, offset 3 → write_data 0xFFFFFF80
  - half, unsigned, offset 2 → 0x000080FF
  - word → 0x80FF7F01
  - hazard1 (read1 = 8) stays high through the RegWrite cycle and drops the next cycle.
- alu_valid held for 4 cycles while 3 loads arrive (FIFO_DEPTH = 2): ld_ready drops after 2 accepts; the loads drain in order once alu_valid falls; there is no lost or duplicated write.
- Load to reg 9 buffered, then alu_reg = 9, alu_data = 0xAAAA: the ALU write occurs, the load entry pops with RegWrite 0, pending[9] clears, and final reg 9 = 0xAAAA.
- Reset asserted while 2 loads are buffered and RegWrite is high: RegWrite is 0 on the next cycle, no buffered write appears after release, and pending = 0.
